// File: rtl/simd_issue_arb_if.sv
// Request, SIMD-unit and result bundle for simd_issue_arb.
// The slave modport is the arbiter's view and the master modport is its environment's view.
interface simd_issue_arb_if #(
    parameter int TAG_W = 9
);
    logic [1:0]       req_vld;
    logic [1:0]       req_rdy;
    logic [12:0]      req_op0;
    logic [12:0]      req_op1;
    logic [67:0]      req_A0;
    logic [67:0]      req_A1;
    logic [67:0]      req_B0;
    logic [67:0]      req_B1;
    logic [TAG_W-1:0] req_tag0;
    logic [TAG_W-1:0] req_tag1;
    logic             blk;
    logic [1:0]       kill_req;
    logic             simd_en;
    logic [12:0]      simd_op;
    logic [67:0]      simd_A;
    logic [67:0]      simd_B;
    logic [67:0]      simd_res;
    logic             res_vld;
    logic             res_req;
    logic [TAG_W-1:0] res_tag;
    logic [67:0]      res_data;
    logic             idle;

    modport slave (
        input  req_vld, req_op0, req_op1, req_A0, req_A1, req_B0, req_B1,
               req_tag0, req_tag1, blk, kill_req, simd_res,
        output req_rdy, simd_en, simd_op, simd_A, simd_B,
               res_vld, res_req, res_tag, res_data, idle
    );

    modport master (
        output req_vld, req_op0, req_op1, req_A0, req_A1, req_B0, req_B1,
               req_tag0, req_tag1, blk, kill_req, simd_res,
        input  req_rdy, simd_en, simd_op, simd_A, simd_B,
               res_vld, res_req, res_tag, res_data, idle
    );
endinterface

// File: rtl/simd_issue_arb.sv
// Two-port round-robin issue arbiter for a fixed-latency SIMD unit; result appears LAT+1 cycles after grant.
// Optional squash of in-flight ops per requester under macro SIMD_ARB_KILL_EN.
module simd_issue_arb #(
    parameter int TAG_W = 9,
    parameter int LAT   = 2
) (
    input  logic            clk,
    input  logic            rst,
    simd_issue_arb_if.slave bus
);
    localparam int NS = LAT + 1;

    logic             r_ptr;
    logic             r_simd_en;
    logic [12:0]      r_simd_op;
    logic [67:0]      r_simd_A;
    logic [67:0]      r_simd_B;
    logic [NS-1:0]    r_tv;
    logic [NS-1:0]    r_treq;
    logic [TAG_W-1:0] r_ttag [NS];

    logic [1:0]       w_kill;
    logic [1:0]       w_elig;
    logic [1:0]       w_rdy;
    logic             w_gidx;
    logic             w_gvld;
    logic [NS-1:0]    w_tv_live;

`ifdef SIMD_ARB_KILL_EN
    assign w_kill = bus.kill_req;
`else
    logic w_unused_kill;
    assign w_unused_kill = ^bus.kill_req;
    assign w_kill        = 2'b00;
`endif

    assign w_elig = bus.req_vld & ~w_kill;

    // ptr only breaks ties; a lone eligible requester always wins.
    always_comb begin
        w_rdy  = 2'b00;
        w_gidx = r_ptr;
        if (rst && !bus.blk) begin
            if (w_elig == 2'b11) begin
                w_gidx = r_ptr;
            end else begin
                w_gidx = w_elig[1];
            end
            w_rdy[w_gidx] = |w_elig;
        end
    end

    assign w_gvld = |w_rdy;

    always_comb begin
        w_tv_live = '0;
        for (int k = 0; k < NS; k++) begin
            w_tv_live[k] = r_tv[k] & ~w_kill[r_treq[k]];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr     <= 1'b0;
            r_simd_en <= 1'b0;
            r_simd_op <= '0;
            r_simd_A  <= '0;
            r_simd_B  <= '0;
        end else begin
            r_simd_en <= w_gvld;
            if (w_gvld) begin
                r_ptr     <= ~w_gidx;
                r_simd_op <= w_gidx ? bus.req_op1 : bus.req_op0;
                r_simd_A  <= w_gidx ? bus.req_A1  : bus.req_A0;
                r_simd_B  <= w_gidx ? bus.req_B1  : bus.req_B0;
            end
        end
    end

    // Stage k holds the op granted k+1 cycles ago; the last stage lines up with simd_res.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tv   <= '0;
            r_treq <= '0;
            for (int k = 0; k < NS; k++) begin
                r_ttag[k] <= '0;
            end
        end else begin
            r_tv[0]   <= w_gvld;
            r_treq[0] <= w_gidx;
            r_ttag[0] <= w_gidx ? bus.req_tag1 : bus.req_tag0;
            for (int k = 1; k < NS; k++) begin
                r_tv[k]   <= w_tv_live[k-1];
                r_treq[k] <= r_treq[k-1];
                r_ttag[k] <= r_ttag[k-1];
            end
        end
    end

    assign bus.req_rdy  = w_rdy;
    assign bus.simd_en  = r_simd_en;
    assign bus.simd_op  = r_simd_op;
    assign bus.simd_A   = r_simd_A;
    assign bus.simd_B   = r_simd_B;
    assign bus.res_vld  = w_tv_live[NS-1];
    assign bus.res_req  = r_treq[NS-1];
    assign bus.res_tag  = r_ttag[NS-1];
    assign bus.res_data = bus.simd_res;
    assign bus.idle     = ~(|r_tv) & ~r_simd_en;
endmodule

// File: tb/tb_simd_issue_arb.sv
// Directed bench for simd_issue_arb (TAG_W=9, LAT=2); kill expectations follow SIMD_ARB_KILL_EN.
module tb_simd_issue_arb;
`ifdef SIMD_ARB_KILL_EN
    localparam bit KILL = 1'b1;
`else
    localparam bit KILL = 1'b0;
`endif

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    localparam logic [67:0] RES_VAL = 68'hA_BCDE_F012_3456_789A;

    simd_issue_arb_if #(.TAG_W(9)) bus ();

    simd_issue_arb #(.TAG_W(9), .LAT(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic mid;
        @(negedge clk);
    endtask

    task automatic drain;
        bus.req_vld  = 2'b00;
        bus.kill_req = 2'b00;
        bus.blk      = 1'b0;
        repeat (5) next_cycle;
        mid;
        tests++;
        if (bus.idle !== 1'b1) begin
            fails++;
            $display("FAIL drain_idle: got %b want 1", bus.idle);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        bus.req_vld = 2'b11;
        repeat (2) @(posedge clk);
        mid;
        tests++;
        if (bus.req_rdy !== 2'b00) begin
            fails++;
            $display("FAIL reset_rdy: got %b want 00", bus.req_rdy);
        end
        tests++;
        if (bus.simd_en !== 1'b0 || bus.res_vld !== 1'b0) begin
            fails++;
            $display("FAIL reset_en_vld: got en=%b vld=%b want 0/0", bus.simd_en, bus.res_vld);
        end
        tests++;
        if (bus.simd_op !== 13'h0 || bus.simd_A !== 68'h0 || bus.res_tag !== 9'h0) begin
            fails++;
            $display("FAIL reset_regs: got op=%h A=%h tag=%h want 0", bus.simd_op, bus.simd_A, bus.res_tag);
        end
        tests++;
        if (bus.idle !== 1'b1) begin
            fails++;
            $display("FAIL reset_idle: got %b want 1", bus.idle);
        end
        next_cycle;
        bus.req_vld = 2'b00;
        rst = 1'b1;
    endtask

    task automatic test_single;
        next_cycle;
        bus.req_vld  = 2'b01;
        bus.req_op0  = 13'h005;
        bus.req_tag0 = 9'h03A;
        bus.req_A0   = 68'h1_2345_6789_ABCD_EF01;
        bus.req_B0   = 68'hF_0000_0000_0000_0055;
        mid;
        tests++;
        if (bus.req_rdy !== 2'b01) begin
            fails++;
            $display("FAIL single_rdy: got %b want 01", bus.req_rdy);
        end
        next_cycle;
        bus.req_vld = 2'b00;
        mid;
        tests++;
        if (bus.simd_en !== 1'b1 || bus.simd_op !== 13'h005) begin
            fails++;
            $display("FAIL single_issue: got en=%b op=%h want 1/005", bus.simd_en, bus.simd_op);
        end
        tests++;
        if (bus.simd_A !== 68'h1_2345_6789_ABCD_EF01 || bus.simd_B !== 68'hF_0000_0000_0000_0055) begin
            fails++;
            $display("FAIL single_operands: got A=%h B=%h", bus.simd_A, bus.simd_B);
        end
        next_cycle;
        mid;
        tests++;
        if (bus.res_vld !== 1'b0 || bus.simd_en !== 1'b0) begin
            fails++;
            $display("FAIL single_c2: got vld=%b en=%b want 0/0", bus.res_vld, bus.simd_en);
        end
        tests++;
        if (bus.simd_op !== 13'h005) begin
            fails++;
            $display("FAIL single_hold: got op=%h want 005", bus.simd_op);
        end
        next_cycle;
        mid;
        tests++;
        if (bus.res_vld !== 1'b1 || bus.res_req !== 1'b0 || bus.res_tag !== 9'h03A) begin
            fails++;
            $display("FAIL single_result: got vld=%b req=%b tag=%h want 1/0/03a",
                     bus.res_vld, bus.res_req, bus.res_tag);
        end
        tests++;
        if (bus.res_data !== RES_VAL) begin
            fails++;
            $display("FAIL single_data: got %h want %h", bus.res_data, RES_VAL);
        end
        next_cycle;
        mid;
        tests++;
        if (bus.res_vld !== 1'b0 || bus.idle !== 1'b1) begin
            fails++;
            $display("FAIL single_after: got vld=%b idle=%b want 0/1", bus.res_vld, bus.idle);
        end
    endtask

    task automatic test_blk;
        bus.req_op1 = 13'h1AB;
        for (int i = 0; i < 3; i++) begin
            next_cycle;
            bus.blk     = 1'b1;
            bus.req_vld = 2'b10;
            mid;
            tests++;
            if (bus.req_rdy !== 2'b00 || bus.simd_en !== 1'b0) begin
                fails++;
                $display("FAIL blk_hold%0d: got rdy=%b en=%b want 00/0", i, bus.req_rdy, bus.simd_en);
            end
        end
        next_cycle;
        bus.blk = 1'b0;
        mid;
        tests++;
        if (bus.req_rdy !== 2'b10 || bus.simd_en !== 1'b0) begin
            fails++;
            $display("FAIL blk_release: got rdy=%b en=%b want 10/0", bus.req_rdy, bus.simd_en);
        end
        next_cycle;
        bus.req_vld = 2'b00;
        mid;
        tests++;
        if (bus.simd_en !== 1'b1 || bus.simd_op !== 13'h1AB) begin
            fails++;
            $display("FAIL blk_issue: got en=%b op=%h want 1/1ab", bus.simd_en, bus.simd_op);
        end
    endtask

    task automatic test_back_to_back;
        logic [1:0] exp_rdy;
        logic       exp_req;
        logic [8:0] exp_tag;
        int         j;
        for (int i = 0; i < 9; i++) begin
            next_cycle;
            bus.req_vld  = (i < 6) ? 2'b11 : 2'b00;
            bus.req_tag0 = 9'(9'h100 + i);
            bus.req_tag1 = 9'(9'h080 + i);
            mid;
            if (i < 6) begin
                exp_rdy = (i % 2 == 1) ? 2'b10 : 2'b01;
                tests++;
                if (bus.req_rdy !== exp_rdy) begin
                    fails++;
                    $display("FAIL b2b_grant%0d: got %b want %b", i, bus.req_rdy, exp_rdy);
                end
            end
            if (i >= 3) begin
                j = i - 3;
                exp_req = (j % 2 == 1);
                exp_tag = exp_req ? 9'(9'h080 + j) : 9'(9'h100 + j);
                tests++;
                if (bus.res_vld !== 1'b1 || bus.res_req !== exp_req || bus.res_tag !== exp_tag) begin
                    fails++;
                    $display("FAIL b2b_result%0d: got vld=%b req=%b tag=%h want 1/%b/%h",
                             j, bus.res_vld, bus.res_req, bus.res_tag, exp_req, exp_tag);
                end
            end
        end
        next_cycle;
        mid;
        tests++;
        if (bus.res_vld !== 1'b0) begin
            fails++;
            $display("FAIL b2b_tail: got vld=%b want 0", bus.res_vld);
        end
    endtask

    task automatic test_reset_mid;
        next_cycle;
        bus.req_vld  = 2'b01;
        bus.req_tag0 = 9'h1AA;
        mid;
        tests++;
        if (bus.req_rdy !== 2'b01) begin
            fails++;
            $display("FAIL rstmid_grant: got %b want 01", bus.req_rdy);
        end
        next_cycle;
        bus.req_vld = 2'b00;
        rst = 1'b0;
        mid;
        tests++;
        if (bus.simd_en !== 1'b0 || bus.req_rdy !== 2'b00) begin
            fails++;
            $display("FAIL rstmid_clear: got en=%b rdy=%b want 0/00", bus.simd_en, bus.req_rdy);
        end
        next_cycle;
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            mid;
            tests++;
            if (bus.res_vld !== 1'b0 || bus.idle !== 1'b1) begin
                fails++;
                $display("FAIL rstmid_quiet%0d: got vld=%b idle=%b want 0/1", k, bus.res_vld, bus.idle);
            end
            next_cycle;
        end
        bus.req_vld = 2'b11;
        mid;
        tests++;
        if (bus.req_rdy !== 2'b01) begin
            fails++;
            $display("FAIL rstmid_ptr: got %b want 01", bus.req_rdy);
        end
        next_cycle;
        bus.req_vld = 2'b00;
    endtask

    task automatic test_kill;
        next_cycle;
        bus.req_vld  = 2'b01;
        bus.req_tag0 = 9'h011;
        mid;
        tests++;
        if (bus.req_rdy !== 2'b01) begin
            fails++;
            $display("FAIL kill_grant0: got %b want 01", bus.req_rdy);
        end
        next_cycle;
        bus.req_vld  = 2'b10;
        bus.req_tag1 = 9'h022;
        mid;
        tests++;
        if (bus.req_rdy !== 2'b10) begin
            fails++;
            $display("FAIL kill_grant1: got %b want 10", bus.req_rdy);
        end
        next_cycle;
        bus.req_vld  = 2'b01;
        bus.kill_req = 2'b01;
        mid;
        tests++;
        if (bus.req_rdy !== (KILL ? 2'b00 : 2'b01)) begin
            fails++;
            $display("FAIL kill_rdy: got %b want %b", bus.req_rdy, KILL ? 2'b00 : 2'b01);
        end
        next_cycle;
        bus.req_vld  = 2'b00;
        bus.kill_req = 2'b00;
        mid;
        tests++;
        if (bus.res_vld !== !KILL || (!KILL && bus.res_tag !== 9'h011)) begin
            fails++;
            $display("FAIL kill_res0: got vld=%b tag=%h want vld=%b", bus.res_vld, bus.res_tag, !KILL);
        end
        next_cycle;
        mid;
        tests++;
        if (bus.res_vld !== 1'b1 || bus.res_req !== 1'b1 || bus.res_tag !== 9'h022) begin
            fails++;
            $display("FAIL kill_res1: got vld=%b req=%b tag=%h want 1/1/022",
                     bus.res_vld, bus.res_req, bus.res_tag);
        end
        next_cycle;
        mid;
        tests++;
        if (bus.res_vld !== !KILL) begin
            fails++;
            $display("FAIL kill_res2: got vld=%b want %b", bus.res_vld, !KILL);
        end
    endtask

    initial begin
        tests        = 0;
        fails        = 0;
        rst          = 1'b0;
        bus.req_vld  = 2'b00;
        bus.req_op0  = '0;
        bus.req_op1  = '0;
        bus.req_A0   = '0;
        bus.req_A1   = '0;
        bus.req_B0   = '0;
        bus.req_B1   = '0;
        bus.req_tag0 = '0;
        bus.req_tag1 = '0;
        bus.blk      = 1'b0;
        bus.kill_req = 2'b00;
        bus.simd_res = RES_VAL;

        test_reset;
        test_single;
        test_blk;
        drain;
        test_back_to_back;
        drain;
        test_reset_mid;
        drain;
        test_kill;
        drain;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
